// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and constants for the OBI memory responder slice.
package cv32e40p_obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  // Request fields, sampled only in the cycle the transfer is granted.
  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  // Response beat: rdata is forced to zero whenever rvalid is low.
  typedef struct packed {
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

  // Merge write data into an existing word, one byte lane per enable bit.
  function automatic logic [OBI_DATA_W-1:0] be_merge(
    input logic [OBI_DATA_W-1:0] old_word,
    input logic [OBI_DATA_W-1:0] wdata,
    input logic [OBI_BE_W-1:0]   be
  );
    logic [OBI_DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < OBI_BE_W; k++) begin
      if (be[k]) begin
        res[k*8 +: 8] = wdata[k*8 +: 8];
      end else begin
        res[k*8 +: 8] = old_word[k*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-latency response delay line. A beat entering stage 0 appears at the
// head (stage LATENCY-1) LATENCY cycles after the grant cycle.
module cv32e40p_obi_resp_pipe
  import cv32e40p_obi_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [OBI_DATA_W-1:0] data_i,
  output obi_rsp_t              rsp_o
);

  obi_rsp_t stage_q [LATENCY];

  // Shift beats toward the head; reset flushes every in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '{rvalid: 1'b0, rdata: {OBI_DATA_W{1'b0}}};
      end
    end else begin
      stage_q[0].rvalid <= valid_i;
      stage_q[0].rdata  <= valid_i ? data_i : {OBI_DATA_W{1'b0}};
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI responder: word RAM, byte-enable writes, grant throttling on an
// outstanding-transaction count, and a fixed-latency in-order response path.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_pkg::*;
#(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [OBI_ADDR_W-1:0] addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  input  logic                  gnt_stall_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  obi_req_t              req_s;
  obi_rsp_t              rsp_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  accept_s;
  logic [OBI_DATA_W-1:0] rd_data_s;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [OBI_DATA_W-1:0] mem_q [MEM_WORDS];

  // Address bits above the index alias; the byte offset is ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_i[OBI_ADDR_W-1:IDX_W+2], addr_i[1:0]};

  assign req_s = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
  assign idx_s = req_s.addr[IDX_W+1:2];

  // Grant looks only at the registered count, so a full queue blocks this
  // cycle even if a response retires in it. req_i gates everything, which
  // keeps X on the other inputs from leaking out while idle.
  assign gnt_o    = req_i & ~gnt_stall_i & (cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~rst_i;
  assign accept_s = req_i & gnt_o;

  // Read data for the accepted transfer; writes answer with zero.
  always_comb begin
    rd_data_s = {OBI_DATA_W{1'b0}};
    if (accept_s && !req_s.we) begin
      rd_data_s = mem_q[idx_s];
    end else begin
      rd_data_s = {OBI_DATA_W{1'b0}};
    end
  end

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && req_s.we) begin
      mem_q[idx_s] <= be_merge(mem_q[idx_s], req_s.wdata, req_s.be);
    end
  end

  // Outstanding count: up on grant, down on response, hold when both.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept_s, rsp_s.rvalid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  cv32e40p_obi_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept_s),
    .data_i  (rd_data_s),
    .rsp_o   (rsp_s)
  );

  assign rvalid_o = rsp_s.rvalid;
  assign rdata_o  = rsp_s.rdata;

endmodule
